// File: rtl/hid_kbd_pkg.sv
// Shared constants and types for the HID boot-keyboard decoder:
// usage codes, modifier masks, ASCII codes, FSM state and report layout.
package hid_kbd_pkg;

  localparam logic [7:0] U_ROLLOVER = 8'h01;
  localparam logic [7:0] U_A        = 8'h04;
  localparam logic [7:0] U_Z        = 8'h1D;
  localparam logic [7:0] U_1        = 8'h1E;
  localparam logic [7:0] U_0        = 8'h27;
  localparam logic [7:0] U_ENTER    = 8'h28;
  localparam logic [7:0] U_ESC      = 8'h29;
  localparam logic [7:0] U_BKSP     = 8'h2A;
  localparam logic [7:0] U_TAB      = 8'h2B;
  localparam logic [7:0] U_SPACE    = 8'h2C;
  localparam logic [7:0] U_RIGHT    = 8'h4F;
  localparam logic [7:0] U_LEFT     = 8'h50;
  localparam logic [7:0] U_DOWN     = 8'h51;
  localparam logic [7:0] U_UP       = 8'h52;

  localparam logic [7:0] MOD_SHIFT_MASK = 8'h22;
  localparam logic [7:0] MOD_CTRL_MASK  = 8'h11;

  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EMIT, ST_GAP} state_t;

  typedef logic [5:0][7:0] slots_t;

  // Byte 1 is reserved and never stored; modifiers are reduced on arrival.
  typedef struct packed {
    logic   shift;
    logic   ctrl;
    slots_t slots;
  } report_t;

  function automatic logic has_usage(slots_t s, logic [7:0] u);
    has_usage = 1'b0;
    for (int i = 0; i < 6; i++)
      if (s[i] == u) has_usage = 1'b1;
  endfunction

endpackage

// File: rtl/hid_kbd_if.sv
// Report byte stream in, character/strobe stream and status out.
interface hid_kbd_if;
  logic [7:0] rep_data;
  logic       rep_valid;
  logic       rep_start;
  logic [7:0] usb_kbd;
  logic       kbd_strobe;
  logic       busy;
  logic       overrun;

  modport master (output rep_data, rep_valid, rep_start,
                  input  usb_kbd, kbd_strobe, busy, overrun);
  modport slave  (input  rep_data, rep_valid, rep_start,
                  output usb_kbd, kbd_strobe, busy, overrun);
endinterface

// File: rtl/hid_usage_to_ascii.sv
// Combinational HID usage -> ASCII (US layout) with Shift/Ctrl;
// arrow keys yield ESC plus a VT52 second byte.
module hid_usage_to_ascii
  import hid_kbd_pkg::*;
(
  input  logic [7:0] usage,
  input  logic       shift,
  input  logic       ctrl,
  output logic [7:0] code,
  output logic       mapped,
  output logic       is_esc_seq,
  output logic [7:0] second
);
  logic [7:0] lo, hi;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    code       = '0;
    mapped     = 1'b0;
    is_esc_seq = 1'b0;
    second     = '0;
    lo         = '0;
    hi         = '0;
    if (usage >= U_A && usage <= U_Z) begin
      mapped = 1'b1;
      if (ctrl)       code = usage - 8'h03;
      else if (shift) code = usage + 8'h3D;
      else            code = usage + 8'h5D;
    end else begin
      mapped = 1'b1;
      case (usage)
        8'h1E:     begin lo = "1";       hi = "!";       end
        8'h1F:     begin lo = "2";       hi = "@";       end
        8'h20:     begin lo = "3";       hi = "#";       end
        8'h21:     begin lo = "4";       hi = "$";       end
        8'h22:     begin lo = "5";       hi = "%";       end
        8'h23:     begin lo = "6";       hi = "^";       end
        8'h24:     begin lo = "7";       hi = "&";       end
        8'h25:     begin lo = "8";       hi = "*";       end
        8'h26:     begin lo = "9";       hi = "(";       end
        U_0:       begin lo = "0";       hi = ")";       end
        U_ENTER:   begin lo = ASCII_CR;  hi = ASCII_CR;  end
        U_ESC:     begin lo = ASCII_ESC; hi = ASCII_ESC; end
        U_BKSP:    begin lo = 8'h08;     hi = 8'h08;     end
        U_TAB:     begin lo = 8'h09;     hi = 8'h09;     end
        U_SPACE:   begin lo = 8'h20;     hi = 8'h20;     end
        8'h2D:     begin lo = "-";       hi = "_";       end
        8'h2E:     begin lo = "=";       hi = "+";       end
        8'h2F:     begin lo = "[";       hi = "{";       end
        8'h30:     begin lo = "]";       hi = "}";       end
        8'h31:     begin lo = 8'h5C;     hi = "|";       end
        8'h32:     begin lo = "#";       hi = "~";       end
        8'h33:     begin lo = ";";       hi = ":";       end
        8'h34:     begin lo = 8'h27;     hi = 8'h22;     end
        8'h35:     begin lo = 8'h60;     hi = "~";       end
        8'h36:     begin lo = ",";       hi = "<";       end
        8'h37:     begin lo = ".";       hi = ">";       end
        8'h38:     begin lo = "/";       hi = "?";       end
        U_RIGHT:   begin lo = ASCII_ESC; hi = ASCII_ESC; is_esc_seq = 1'b1; second = "C"; end
        U_LEFT:    begin lo = ASCII_ESC; hi = ASCII_ESC; is_esc_seq = 1'b1; second = "D"; end
        U_DOWN:    begin lo = ASCII_ESC; hi = ASCII_ESC; is_esc_seq = 1'b1; second = "B"; end
        U_UP:      begin lo = ASCII_ESC; hi = ASCII_ESC; is_esc_seq = 1'b1; second = "A"; end
        default:   mapped = 1'b0;
      endcase
      code = shift ? hi : lo;
    end
  end

endmodule

// File: rtl/hid_kbd_decoder.sv
// Assembles 8-byte boot reports, emits newly pressed keys as a strobed
// character stream, and generates typematic repeat for the last new key.
module hid_kbd_decoder
  import hid_kbd_pkg::*;
#(
  parameter int STROBE_GAP   = 16,
  parameter int REPEAT_DELAY = 16000000,
  parameter int REPEAT_RATE  = 2000000,
  parameter int CNT_W        = 25
) (
  input logic      clk,
  input logic      rstn,
  hid_kbd_if.slave bus
);
  localparam int GAP_W = (STROBE_GAP > 2) ? $clog2(STROBE_GAP) : 1;

  report_t              asm_q, pend_q, cur_q;
  slots_t               prev_q;
  logic [3:0]           idx_q;
  logic [2:0]           slot_wr;
  logic                 asm_done_q, pend_valid_q, overrun_q, take;
  state_t               state_q, state_d;
  logic [2:0]           slot_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 second_pend_q, rep_mode_q, new_seen_q, finish;
  logic [7:0]           second_q, last_new_q, rep_key_q, usb_kbd_q;
  logic [CNT_W-1:0]     rep_cnt_q;
  logic [7:0]           cur_slot, map_usage, map_code, map_second;
  logic                 map_mapped, map_esc, slot_new, rep_due, last_slot;

  assign slot_wr = idx_q[2:0] - 3'd2;

  // NOTE: the assembly buffer is reset so a report cut short by reset never completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      asm_q      <= '0;
      idx_q      <= '0;
      asm_done_q <= 1'b0;
    end else begin
      asm_done_q <= 1'b0;
      if (bus.rep_valid) begin
        if (bus.rep_start) begin
          asm_q.shift <= |(bus.rep_data & MOD_SHIFT_MASK);
          asm_q.ctrl  <= |(bus.rep_data & MOD_CTRL_MASK);
          idx_q       <= 4'd1;
        end else if (idx_q < 4'd8) begin
          if (idx_q == 4'd0) begin
            asm_q.shift <= |(bus.rep_data & MOD_SHIFT_MASK);
            asm_q.ctrl  <= |(bus.rep_data & MOD_CTRL_MASK);
          end else if (idx_q >= 4'd2) begin
            asm_q.slots[slot_wr] <= bus.rep_data;
          end
          idx_q      <= idx_q + 4'd1;
          asm_done_q <= (idx_q == 4'd7);
        end
      end
    end
  end

  // Rollover reports are dropped before they ever become pending.
  assign take = (state_q == ST_IDLE) && pend_valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (take) pend_valid_q <= 1'b0;
      if (asm_done_q && !has_usage(asm_q.slots, U_ROLLOVER)) begin
        pend_q       <= asm_q;
        pend_valid_q <= 1'b1;
        overrun_q    <= pend_valid_q && !take;
      end
    end
  end

  assign cur_slot  = cur_q.slots[slot_q];
  assign map_usage = (state_q == ST_IDLE) ? rep_key_q : cur_slot;
  assign last_slot = (slot_q == 3'd5);
  assign slot_new  = (cur_slot != 8'h00) && map_mapped && !has_usage(prev_q, cur_slot);
  // Counter reaches zero on this edge (1) or already waited there (0).
  assign rep_due   = (rep_key_q != 8'h00) && (rep_cnt_q <= CNT_W'(1));

  hid_usage_to_ascii u_map (
    .usage      (map_usage),
    .shift      (cur_q.shift),
    .ctrl       (cur_q.ctrl),
    .code       (map_code),
    .mapped     (map_mapped),
    .is_esc_seq (map_esc),
    .second     (map_second)
  );

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (pend_valid_q) state_d = ST_SCAN;
               else if (rep_due) state_d = ST_EMIT;
      ST_SCAN: if (slot_new) state_d = ST_EMIT;
               else if (last_slot) begin state_d = ST_IDLE; finish = 1'b1; end
               else state_d = ST_SCAN;
      ST_EMIT: state_d = ST_GAP;
      ST_GAP:  if (gap_q == '0) begin
                 if (second_pend_q)   state_d = ST_EMIT;
                 else if (rep_mode_q) state_d = ST_IDLE;
                 else if (last_slot)  begin state_d = ST_IDLE; finish = 1'b1; end
                 else                 state_d = ST_SCAN;
               end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.kbd_strobe = (state_q == ST_EMIT);
    bus.busy       = (state_q != ST_IDLE);
  end

  assign bus.usb_kbd = usb_kbd_q;
  assign bus.overrun = overrun_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_q <= '0;  prev_q <= '0;  slot_q <= '0;  gap_q <= '0;
      second_pend_q <= 1'b0;  second_q <= '0;  rep_mode_q <= 1'b0;
      new_seen_q <= 1'b0;  last_new_q <= '0;  rep_key_q <= '0;
      rep_cnt_q <= '0;  usb_kbd_q <= '0;
    end else begin
      if (rep_cnt_q != '0) rep_cnt_q <= rep_cnt_q - CNT_W'(1);
      case (state_q)
        ST_IDLE:
          if (pend_valid_q) begin
            cur_q      <= pend_q;
            slot_q     <= '0;
            new_seen_q <= 1'b0;
            rep_mode_q <= 1'b0;
          end else if (rep_due) begin
            rep_mode_q    <= 1'b1;
            usb_kbd_q     <= map_code;
            second_pend_q <= map_esc;
            second_q      <= map_second;
            rep_cnt_q     <= CNT_W'(REPEAT_RATE);
          end
        ST_SCAN:
          if (slot_new) begin
            usb_kbd_q     <= map_code;
            second_pend_q <= map_esc;
            second_q      <= map_second;
            new_seen_q    <= 1'b1;
            last_new_q    <= cur_slot;
            rep_cnt_q     <= CNT_W'(REPEAT_DELAY);
          end else if (!last_slot) begin
            slot_q <= slot_q + 3'd1;
          end
        ST_EMIT: gap_q <= GAP_W'(STROBE_GAP - 2);
        ST_GAP:
          if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
          end else if (second_pend_q) begin
            usb_kbd_q     <= second_q;
            second_pend_q <= 1'b0;
          end else if (!rep_mode_q && !last_slot) begin
            slot_q <= slot_q + 3'd1;
          end
        default: ;
      endcase
      if (finish) begin
        prev_q <= cur_q.slots;
        if (new_seen_q)                           rep_key_q <= last_new_q;
        else if (!has_usage(cur_q.slots, rep_key_q)) rep_key_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hid_kbd_decoder.sv
// Scoreboard bench: stimulus queues expected (code, cycle) pairs, a monitor
// pops and compares on every kbd_strobe.
module tb_hid_kbd_decoder;
  localparam int GAP  = 16;
  localparam int DLY  = 100;
  localparam int RATE = 20;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  hid_kbd_if bus ();

  hid_kbd_decoder #(
    .STROBE_GAP(GAP), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(25)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int ovr_cnt = 0;
  int checks  = 0;
  int errors  = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.overrun) ovr_cnt <= ovr_cnt + 1;

  typedef struct { logic [7:0] code; int at; } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_chr(input logic [7:0] c, input int at);
    exp_q.push_back('{code: c, at: at});
  endtask

  always @(negedge clk) begin
    if (rstn && bus.kbd_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: actual 0x%0h at cycle %0d required no strobe",
                 bus.usb_kbd, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_code", {24'h0, bus.usb_kbd}, {24'h0, e.code});
        if (e.at >= 0) check("strobe_cycle", cyc, e.at);
      end
    end
  end

  // Returns in n the clock-edge index at which byte 7 was sampled.
  task automatic send_report(input logic [7:0] mods, input logic [47:0] slots, output int n);
    @(negedge clk);
    bus.rep_valid = 1'b1; bus.rep_start = 1'b1; bus.rep_data = mods;
    @(negedge clk);
    bus.rep_start = 1'b0; bus.rep_data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.rep_data = slots[47 - 8*i -: 8];
    end
    @(posedge clk);
    #1 n = cyc;
    @(negedge clk);
    bus.rep_valid = 1'b0; bus.rep_data = 8'h00;
  endtask

  task automatic wait_idle();
    int k = 0;
    repeat (3) @(negedge clk);
    while (bus.busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", (k < 2000), 1);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic release_keys();
    int n;
    send_report(8'h00, 48'h0, n);
    wait_idle();
  endtask

  initial begin
    int n, m, p, lows, ovr_base, k;
    bus.rep_valid = 1'b0; bus.rep_start = 1'b0; bus.rep_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_usb_kbd", bus.usb_kbd, 0);
    check("reset_strobe",  bus.kbd_strobe, 0);
    check("reset_busy",    bus.busy, 0);
    check("reset_overrun", bus.overrun, 0);
    rstn = 1'b1;

    // Single key, then empty report: exactly one 'a' at byte7+3.
    send_report(8'h00, 48'h04_00_00_00_00_00, n);
    expect_chr(8'h61, n + 3);
    wait_idle();
    release_keys();

    // Shift digit, Ctrl letter, Shift letter, Ctrl+Shift letter.
    send_report(8'h02, 48'h1E_00_00_00_00_00, n); expect_chr(8'h21, n + 3); wait_idle();
    send_report(8'h01, 48'h06_00_00_00_00_00, n); expect_chr(8'h03, n + 3); wait_idle();
    release_keys();
    send_report(8'h20, 48'h04_00_00_00_00_00, n); expect_chr(8'h41, n + 3); wait_idle();
    send_report(8'h12, 48'h05_00_00_00_00_00, n); expect_chr(8'h02, n + 3); wait_idle();
    release_keys();

    // Three new keys in one report: shifted punctuation and Enter, 17 cycles apart.
    send_report(8'h02, 48'h2D_38_28_00_00_00, n);
    expect_chr(8'h5F, n + 3); expect_chr(8'h3F, n + 20); expect_chr(8'h0D, n + 37);
    wait_idle();
    release_keys();

    // Up arrow: ESC then 'A' exactly GAP cycles apart, busy held in between.
    send_report(8'h00, 48'h52_00_00_00_00_00, n);
    expect_chr(8'h1B, n + 3); expect_chr(8'h41, n + 3 + GAP);
    wait_cycle(n + 3);
    lows = 0;
    for (int i = 0; i <= GAP; i++) begin
      if (!bus.busy) lows++;
      @(negedge clk);
    end
    check("arrow_busy_low_cycles", lows, 0);
    wait_idle();
    release_keys();

    // Held key across reports, then a second key becomes the repeat key.
    send_report(8'h00, 48'h04_00_00_00_00_00, n); expect_chr(8'h61, n + 3); wait_idle();
    send_report(8'h00, 48'h04_00_00_00_00_00, n); wait_idle();
    send_report(8'h00, 48'h04_05_00_00_00_00, m);
    expect_chr(8'h62, m + 4);
    expect_chr(8'h62, m + 4 + DLY);
    expect_chr(8'h62, m + 4 + DLY + RATE);
    expect_chr(8'h62, m + 4 + DLY + 2*RATE);
    wait_cycle(m + 5 + DLY + 2*RATE);
    release_keys();
    wait_cycle(cyc + 250);

    // Hold a single key: repeats at +DLY, +DLY+RATE, +DLY+2*RATE, stop on release.
    send_report(8'h00, 48'h04_00_00_00_00_00, p);
    expect_chr(8'h61, p + 3);
    expect_chr(8'h61, p + 3 + DLY);
    expect_chr(8'h61, p + 3 + DLY + RATE);
    expect_chr(8'h61, p + 3 + DLY + 2*RATE);
    wait_cycle(p + 4 + DLY + 2*RATE);
    release_keys();
    wait_cycle(cyc + 250);

    // Two reports complete while busy: one overrun, only the later one emitted.
    ovr_base = ovr_cnt;
    send_report(8'h00, 48'h04_00_00_00_00_00, n); expect_chr(8'h61, n + 3);
    send_report(8'h00, 48'h05_00_00_00_00_00, m);
    send_report(8'h00, 48'h06_00_00_00_00_00, m); expect_chr(8'h63, -1);
    wait_idle();
    check("overrun_pulses", ovr_cnt - ovr_base, 1);
    release_keys();

    // Rollover report is discarded: previous report still holds 04.
    send_report(8'h00, 48'h04_00_00_00_00_00, n); expect_chr(8'h61, n + 3); wait_idle();
    send_report(8'h00, 48'h01_05_00_00_00_00, n); wait_idle();
    send_report(8'h00, 48'h04_05_00_00_00_00, n); expect_chr(8'h62, n + 4); wait_idle();
    release_keys();

    // Reset mid-GAP clears outputs at once and forgets the previous report.
    send_report(8'h00, 48'h04_00_00_00_00_00, n); expect_chr(8'h61, n + 3);
    wait_cycle(n + 8);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_usb_kbd", bus.usb_kbd, 0);
    check("rst_mid_strobe",  bus.kbd_strobe, 0);
    check("rst_mid_busy",    bus.busy, 0);
    check("rst_mid_overrun", bus.overrun, 0);
    @(negedge clk);
    rstn = 1'b1;
    send_report(8'h00, 48'h04_00_00_00_00_00, n); expect_chr(8'h61, n + 3);
    wait_idle();
    release_keys();

    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
